fetch_unit: RTL

- Instruction fetch stage for the RISC-V core.
- Owns the fetch PC and issues word requests to instruction memory over a request/grant/response interface.
- Buffers returned instructions in a small FIFO and presents them to the control unit and datapath with a valid/ready handshake.
- Applies PC redirects raised by the control unit (PCSrc), discarding stale in-flight and buffered instructions.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: NOP, reset vector,
// fetch buffer entry type and base opcodes.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched entries.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   wptr_d;
  logic [AW-1:0]   rptr_q;
  logic [AW-1:0]   rptr_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      flush_i: begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end
      default: begin
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response, buffer.
// Optional FETCH_STALL_CNT_EN adds a starvation counter output.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                    BUF_DEPTH   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   PCSrc_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fpc_q;
  logic [ADDR_WIDTH-1:0] fpc_d;
  logic [ADDR_WIDTH-1:0] rpc_q;
  logic [ADDR_WIDTH-1:0] rpc_d;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [CW-1:0]         outst_q;
  logic [CW-1:0]         outst_d;
  logic [CW-1:0]         drop_q;
  logic [CW-1:0]         drop_d;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           inflight;
  logic                  fire;
  logic                  rsp;
  logic                  discard;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  entry_t                wdata;
  entry_t                head;
  logic                  unused_tgt;

  assign unused_tgt = ^branch_target_i[1:0];
  assign tgt = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};

  // credits come from registered counts only
  assign inflight = {1'b0, outst_q} + {1'b0, fifo_cnt};

  assign imem_req_o = rst_ni && !PCSrc_i && !fifo_full
                   && (inflight < (CW+1)'(BUF_DEPTH));
  assign imem_addr_o = fpc_q;

  assign fire    = imem_req_o && imem_gnt_i;
  assign rsp     = imem_rvalid_i && (outst_q != '0);
  assign discard = rsp && (drop_q != '0);
  assign push    = rsp && !discard && !PCSrc_i;
  assign pop     = instr_valid_o && instr_ready_i && !PCSrc_i;

  assign wdata.instr = imem_rdata_i;
  assign wdata.pc    = rpc_q;

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (PCSrc_i),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o = fifo_empty ? INSTR_WIDTH'(NOP_INSTR) : head.instr;
  assign pc_o    = fifo_empty ? '0 : head.pc;

  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(fire) - CW'(rsp);
    if (fire)    fpc_d  = fpc_q + ADDR_WIDTH'(4);
    if (discard) drop_d = drop_q - CW'(1);
    if (push)    rpc_d  = rpc_q + ADDR_WIDTH'(4);
    // everything still in flight after this cycle is stale
    if (PCSrc_i) begin
      fpc_d  = tgt;
      rpc_d  = tgt;
      drop_d = outst_q - CW'(rsp);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (instr_ready_i && !instr_valid_o && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
